dual_width_serializer: RTL and testbench

DUAL_WIDTH_SERIALIZER -- requirements
Module: dual_width_serializer

---
 rtl/dual_width_serializer.sv | 172 +++++++++++++++++
 tb/tb_dual_width_serializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_width_serializer.sv
// Serializes {in_b,in_a} word pairs (in_a LSB first, then in_b) through a 2-entry FIFO.
// Optional feature macro: DUAL_WIDTH_SERIALIZER_PARITY_EN appends an even-parity bit per frame.
module dual_width_serializer #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_a,
  input  logic [5:0]      in_b,
  output logic            ser_out,
  output logic            ser_frame,
  output logic            ser_sof,
  output logic            busy,
  output logic [7:0]      frame_cnt
);
  localparam int SIZETWO = 6;
  localparam int FLEN    = SIZE + SIZETWO;
  localparam int IDXW    = $clog2(FLEN);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FLEN - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef DUAL_WIDTH_SERIALIZER_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif

  logic [FLEN-1:0] mem_q [0:1];
  logic [FLEN-1:0] mem_d [0:1];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic [1:0]      state_q, state_d;
  logic [FLEN-1:0] shift_q, shift_d;
  logic [IDXW-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
`ifdef DUAL_WIDTH_SERIALIZER_PARITY_EN
  logic            parity_q, parity_d;
`endif
  logic            push_s;
  logic            pop_s;

  // Next-state logic for FIFO and frame FSM
  always_comb begin
    mem_d[0]    = mem_q[0];
    mem_d[1]    = mem_q[1];
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    frame_cnt_d = frame_cnt_q;
`ifdef DUAL_WIDTH_SERIALIZER_PARITY_EN
    parity_d    = parity_q;
`endif
    // in_ready comes only from registered count, so a full FIFO never accepts even during a pop
    push_s = in_valid && (count_q < 2'd2);
    pop_s  = (state_q == ST_IDLE) && (count_q != 2'd0);

    if (push_s) begin
      mem_d[wr_ptr_q] = {in_b, in_a};
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          shift_d   = mem_q[rd_ptr_q];
          rd_ptr_d  = ~rd_ptr_q;
          bit_idx_d = {IDXW{1'b0}};
          state_d   = ST_SHIFT;
`ifdef DUAL_WIDTH_SERIALIZER_PARITY_EN
          parity_d  = ^mem_q[rd_ptr_q];
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_d   = shift_q >> 1;
        bit_idx_d = bit_idx_q + IDXW'(1);
        if (bit_idx_q == LAST_IDX) begin
`ifdef DUAL_WIDTH_SERIALIZER_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d     = ST_IDLE;
          frame_cnt_d = frame_cnt_q + 8'd1;
`endif
        end else begin
          state_d = ST_SHIFT;
        end
      end
`ifdef DUAL_WIDTH_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        state_d     = ST_IDLE;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]    <= {FLEN{1'b0}};
      mem_q[1]    <= {FLEN{1'b0}};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      state_q     <= ST_IDLE;
      shift_q     <= {FLEN{1'b0}};
      bit_idx_q   <= {IDXW{1'b0}};
      frame_cnt_q <= 8'd0;
`ifdef DUAL_WIDTH_SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      mem_q[0]    <= mem_d[0];
      mem_q[1]    <= mem_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef DUAL_WIDTH_SERIALIZER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Output decode straight from registered state
  always_comb begin
    ser_out   = 1'b0;
    ser_frame = 1'b0;
    ser_sof   = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        ser_out   = shift_q[0];
        ser_frame = 1'b1;
        ser_sof   = (bit_idx_q == {IDXW{1'b0}});
      end
`ifdef DUAL_WIDTH_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        ser_out   = parity_q;
        ser_frame = 1'b1;
      end
`endif
      default: begin
        ser_out   = 1'b0;
        ser_frame = 1'b0;
        ser_sof   = 1'b0;
      end
    endcase
  end

  assign in_ready  = (count_q < 2'd2);
  assign busy      = (state_q != ST_IDLE) || (count_q != 2'd0);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dual_width_serializer.sv
// Scoreboard bench for dual_width_serializer: random and directed word pairs, expected bit
// stream built from the frame rules and checked by an independent monitor.
module tb_dual_width_serializer;
  localparam int FLEN = 14;
`ifdef DUAL_WIDTH_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid, in_ready;
  logic [7:0] in_a;
  logic [5:0] in_b;
  logic       ser_out, ser_frame, ser_sof, busy;
  logic [7:0] frame_cnt;

  logic       in_valid5, in_ready5;
  logic [4:0] in_a5;
  logic [5:0] in_b5;
  logic       ser_out5, ser_frame5, ser_sof5, busy5;
  logic [7:0] frame_cnt5;

  dual_width_serializer u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .ser_out(ser_out), .ser_frame(ser_frame),
    .ser_sof(ser_sof), .busy(busy), .frame_cnt(frame_cnt)
  );

  dual_width_serializer #(.SIZE(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_a(in_a5), .in_b(in_b5), .ser_out(ser_out5), .ser_frame(ser_frame5),
    .ser_sof(ser_sof5), .busy(busy5), .frame_cnt(frame_cnt5)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic sof;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   model_frames = 0;
  logic prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected frame: word {b,a} bit by bit from LSB, then optional even parity of the whole word
  function automatic void model_push(input logic [7:0] a, input logic [5:0] b);
    logic [FLEN-1:0] w;
    exp_t e;
    w = {b, a};
    for (int i = 0; i < FLEN; i++) begin
      e.b    = w[i];
      e.sof  = (i == 0);
      e.last = (i == FLEN - 1) && (PAR == 0);
      exp_q.push_back(e);
    end
    if (PAR != 0) begin
      e.b    = ^w;
      e.sof  = 1'b0;
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endfunction

  // Offer a word from posedge+1 until accepted; returns at posedge+1 after acceptance
  task automatic drive(input logic [7:0] a, input logic [5:0] b, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        model_push(a, b);
        acc = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    check("accept", acc, 1);
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    check("drain", done, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_last = 1'b0;
      model_frames = 0;
    end else if (ser_frame) begin
      check("gap_after_frame", prev_last, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_bit", ser_frame, 0);
        prev_last = 1'b0;
      end else begin
        e = exp_q.pop_front();
        check("ser_out", ser_out, e.b);
        check("ser_sof", ser_sof, e.sof);
        if (e.last) model_frames++;
        prev_last = e.last;
      end
    end else begin
      check("idle_out", {ser_out, ser_sof}, 0);
      prev_last = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic found;
    logic [15:0] bits5;
    logic [15:0] exp5;
    int n5;

    in_valid = 1'b0; in_a = 8'd0; in_b = 6'd0;
    in_valid5 = 1'b0; in_a5 = 5'd0; in_b5 = 6'd0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_frame", {ser_frame, ser_out, ser_sof}, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First edge after release accepts; then abort a frame at bit 5 with a word still queued
    drive(8'($urandom), 6'($urandom), w);
    check("first_push_wait", w, 0);
    drive(8'($urandom), 6'($urandom), w);
    in_valid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      if (ser_sof) found = 1'b1;
    end
    check("sof_seen", found, 1);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_frame", {ser_frame, ser_out, ser_sof}, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_abort_busy", busy, 0);
    check("post_abort_cnt", frame_cnt, 0);

    // Directed A5/2C frame with latency check
    @(posedge clk);
    #1;
    drive(8'hA5, 6'h2C, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_idle_cycle", ser_frame, 0);
    @(negedge clk);
    check("lat_bit0_sof", {ser_frame, ser_sof}, 2'b11);
    wait_drain();
    check("cnt_after_one", frame_cnt, 1);

    // Four back-to-back offers: three accepted at once, the fourth held
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      drive(8'($urandom), 6'($urandom), w);
      check("b2b_held", (w != 0), (i == 3));
    end
    in_valid = 1'b0;
    wait_drain();
    check("cnt_after_b2b", frame_cnt, model_frames[7:0]);

    // Random stream up to 256 frames total since reset
    @(posedge clk);
    #1;
    for (int n = 0; n < 251; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      drive(8'($urandom), 6'($urandom), w);
    end
    in_valid = 1'b0;
    wait_drain();
    check("frames_seen", model_frames, 256);
    check("frame_cnt_wrap", frame_cnt, 0);

    // SIZE=5 instance: five ones then six zeros
    @(posedge clk);
    #1;
    in_valid5 = 1'b1; in_a5 = 5'h1F; in_b5 = 6'h00;
    @(negedge clk);
    check("s5_ready", in_ready5, 1);
    @(posedge clk);
    #1;
    in_valid5 = 1'b0;
    bits5 = 16'd0;
    n5 = 0;
    repeat (40) begin
      @(negedge clk);
      if (ser_frame5 && n5 < 16) begin
        bits5[n5] = ser_out5;
        n5++;
      end
    end
    exp5 = {5'd0, 6'h00, 5'h1F};
    if (PAR != 0) exp5[11] = ^exp5;
    check("s5_len", n5, 11 + PAR);
    check("s5_bits", bits5, exp5);
    check("s5_cnt", frame_cnt5, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
